// File: rtl/arm_frame_buf_pkg.sv
// Shared types and constants for the ARM double-buffered frame capture block.
package arm_frame_buf_pkg;

    localparam int CNT_W = 16;

    typedef enum logic {
        W_WAIT_SOF = 1'b0,
        W_FILL     = 1'b1
    } wstate_e;

    typedef enum logic {
        R_EMPTY = 1'b0,
        R_FULL  = 1'b1
    } rstate_e;

    function automatic int unsigned depth_f(input int unsigned bitwidth);
        return 2 ** (bitwidth + 4);
    endfunction

endpackage

// File: rtl/arm_frame_buf_ram.sv
// Two-bank simple dual-port frame store: address is {bank, index}, registered read.
module arm_frame_ram
    import arm_frame_buf_pkg::*;
#(
    parameter int AW = 13,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW:0]   waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW:0]   raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [2**(AW+1)];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is cleared; the array itself keeps its contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/arm_frame_buf.sv
// Captures one frame of accumulator output into a write bank and publishes it to the ARM,
// handing banks over on completion and releasing the published bank on an ARM_ACK rising edge.
module arm_frame_buf
    import arm_frame_buf_pkg::*;
#(
    parameter int BITWIDTH           = 9,
    parameter int ARM_BUS_DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ARM_BUS_DATA_WIDTH-1:0] din,
    input  logic                          din_valid,
    input  logic                          din_sof,
    input  logic                          ARM_EN,
    input  logic                          ARM_ACK,
    input  logic [BITWIDTH+3:0]           ARM_ADDR,
    output logic [ARM_BUS_DATA_WIDTH-1:0] ARM_DATA,
    output logic                          ARM_DATA_READY,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic [CNT_W-1:0]              sof_err_cnt
);

    localparam int AW    = BITWIDTH + 4;
    localparam int DEPTH = depth_f(BITWIDTH);

    wstate_e           w_state_q, w_state_d;
    rstate_e           r_state_q, r_state_d;
    logic [AW-1:0]     widx_q, widx_d;
    logic              wb_q, wb_d;
    logic              ack_q;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]  sof_err_cnt_q, sof_err_cnt_d;

    logic              we;
    logic [AW-1:0]     wr_idx;
    logic              frame_done;
    logic              sof_err_inc;
    logic              wb_toggle;
    logic              drop_inc;
    logic              ack_rise;

    assign ack_rise = ARM_ACK & ~ack_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q     <= W_WAIT_SOF;
            r_state_q     <= R_EMPTY;
            widx_q        <= '0;
            wb_q          <= 1'b0;
            ack_q         <= 1'b0;
            drop_cnt_q    <= '0;
            sof_err_cnt_q <= '0;
        end else begin
            w_state_q     <= w_state_d;
            r_state_q     <= r_state_d;
            widx_q        <= widx_d;
            wb_q          <= wb_d;
            ack_q         <= ARM_ACK;
            drop_cnt_q    <= drop_cnt_d;
            sof_err_cnt_q <= sof_err_cnt_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_WAIT_SOF: begin
                if (ARM_EN && din_valid && din_sof) begin
                    w_state_d = W_FILL;
                end
            end
            W_FILL: begin
                if (!ARM_EN) begin
                    w_state_d = W_WAIT_SOF;
                end else if (din_valid && !din_sof && (widx_q == {AW{1'b1}})) begin
                    w_state_d = W_WAIT_SOF;
                end
            end
            default: w_state_d = W_WAIT_SOF;
        endcase
    end

    always_comb begin
        we          = 1'b0;
        wr_idx      = '0;
        widx_d      = widx_q;
        frame_done  = 1'b0;
        sof_err_inc = 1'b0;
        case (w_state_q)
            W_WAIT_SOF: begin
                if (ARM_EN && din_valid && din_sof) begin
                    we     = 1'b1;
                    widx_d = AW'(1);
                end
            end
            W_FILL: begin
                if (!ARM_EN) begin
                    widx_d = '0;
                end else if (din_valid && din_sof) begin
                    we          = 1'b1;
                    widx_d      = AW'(1);
                    sof_err_inc = 1'b1;
                end else if (din_valid) begin
                    we     = 1'b1;
                    wr_idx = widx_q;
                    widx_d = widx_q + AW'(1);
                    frame_done = (widx_q == {AW{1'b1}});
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_EMPTY: if (frame_done) r_state_d = R_FULL;
            R_FULL:  if (ack_rise && !frame_done) r_state_d = R_EMPTY;
            default: r_state_d = R_EMPTY;
        endcase
    end

    // A release coinciding with completion hands the new frame straight to the ARM.
    always_comb begin
        wb_toggle = 1'b0;
        drop_inc  = 1'b0;
        case (r_state_q)
            R_EMPTY: wb_toggle = frame_done;
            R_FULL: begin
                wb_toggle = frame_done && ack_rise;
                drop_inc  = frame_done && !ack_rise;
            end
            default: ;
        endcase
    end

    always_comb begin
        wb_d          = wb_q ^ wb_toggle;
        drop_cnt_d    = drop_cnt_q;
        sof_err_cnt_d = sof_err_cnt_q;
        if (drop_inc && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
        if (sof_err_inc && (sof_err_cnt_q != '1)) begin
            sof_err_cnt_d = sof_err_cnt_q + CNT_W'(1);
        end
    end

    arm_frame_ram #(
        .AW (AW),
        .DW (ARM_BUS_DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .waddr_i ({wb_q, wr_idx}),
        .wdata_i (din),
        .raddr_i ({~wb_q, ARM_ADDR}),
        .rdata_o (ARM_DATA)
    );

    assign ARM_DATA_READY = (r_state_q == R_FULL);
    assign drop_cnt       = drop_cnt_q;
    assign sof_err_cnt    = sof_err_cnt_q;

endmodule

// File: tb/tb_arm_frame_buf.sv
// Directed bench for arm_frame_buf with BITWIDTH=2 (64-word frames).
module tb_arm_frame_buf;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic        din_valid;
    logic        din_sof;
    logic        ARM_EN;
    logic        ARM_ACK;
    logic [5:0]  ARM_ADDR;
    logic [15:0] ARM_DATA;
    logic        ARM_DATA_READY;
    logic [15:0] drop_cnt;
    logic [15:0] sof_err_cnt;

    int checks = 0;
    int errors = 0;

    arm_frame_buf #(
        .BITWIDTH           (2),
        .ARM_BUS_DATA_WIDTH (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .din            (din),
        .din_valid      (din_valid),
        .din_sof        (din_sof),
        .ARM_EN         (ARM_EN),
        .ARM_ACK        (ARM_ACK),
        .ARM_ADDR       (ARM_ADDR),
        .ARM_DATA       (ARM_DATA),
        .ARM_DATA_READY (ARM_DATA_READY),
        .drop_cnt       (drop_cnt),
        .sof_err_cnt    (sof_err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input int value, input bit sof);
        din       = 16'(value);
        din_valid = 1'b1;
        din_sof   = sof;
        tick();
        din_valid = 1'b0;
        din_sof   = 1'b0;
    endtask

    task automatic send_words(input int base, input int first, input int n, input bit first_sof);
        for (int k = 0; k < n; k++) begin
            send_word(base + first + k, first_sof && (k == 0));
        end
    endtask

    task automatic read_chk(input string tag, input int addr, input int exp);
        ARM_ADDR = 6'(addr);
        tick();
        chk(tag, ARM_DATA, 16'(exp));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        din_sof   = 1'b0;
        ARM_EN    = 1'b0;
        ARM_ACK   = 1'b0;
        ARM_ADDR  = '0;
        tick();
        tick();
        chk("rst_ready", {15'd0, ARM_DATA_READY}, 16'd0);
        chk("rst_data", ARM_DATA, 16'h0000);
        chk("rst_drop", drop_cnt, 16'd0);
        chk("rst_soferr", sof_err_cnt, 16'd0);
        rst = 1'b0;
        tick();

        // First frame: ready rises only after the 64th write.
        ARM_EN = 1'b1;
        send_words(16'h100, 0, 63, 1'b1);
        chk("f1_ready_before_last", {15'd0, ARM_DATA_READY}, 16'd0);
        send_words(16'h100, 63, 1, 1'b0);
        chk("f1_ready_after_last", {15'd0, ARM_DATA_READY}, 16'd1);
        read_chk("f1_addr5", 5, 16'h105);
        read_chk("f1_addr63", 63, 16'h13F);

        // Second frame while the first is still held is dropped.
        send_words(16'h200, 0, 64, 1'b1);
        chk("drop_cnt1", drop_cnt, 16'd1);
        chk("drop_ready", {15'd0, ARM_DATA_READY}, 16'd1);
        read_chk("drop_addr0_old", 0, 16'h100);

        // Release, then an edge while empty changes nothing.
        ARM_ACK = 1'b1;
        tick();
        chk("release_ready", {15'd0, ARM_DATA_READY}, 16'd0);
        ARM_ACK = 1'b0;
        tick();
        ARM_ACK = 1'b1;
        tick();
        chk("ack_empty_ignored", {15'd0, ARM_DATA_READY}, 16'd0);
        ARM_ACK = 1'b0;

        // ACK edge on the same cycle as the final word publishes the new frame.
        do_reset();
        send_words(16'h300, 0, 64, 1'b1);
        chk("fa_ready", {15'd0, ARM_DATA_READY}, 16'd1);
        send_words(16'h400, 0, 63, 1'b1);
        ARM_ACK = 1'b1;
        send_words(16'h400, 63, 1, 1'b0);
        chk("same_cycle_ready", {15'd0, ARM_DATA_READY}, 16'd1);
        chk("same_cycle_drop", drop_cnt, 16'd0);
        read_chk("same_cycle_addr0", 0, 16'h400);
        read_chk("same_cycle_addr63", 63, 16'h43F);
        ARM_ACK = 1'b0;
        tick();
        ARM_ACK = 1'b1;
        tick();
        chk("release2_ready", {15'd0, ARM_DATA_READY}, 16'd0);
        ARM_ACK = 1'b0;

        // Early sof restarts the frame.
        send_words(16'h500, 0, 20, 1'b1);
        send_words(16'h600, 0, 64, 1'b1);
        chk("soferr_cnt", sof_err_cnt, 16'd1);
        chk("soferr_ready", {15'd0, ARM_DATA_READY}, 16'd1);
        read_chk("soferr_addr0", 0, 16'h600);
        read_chk("soferr_addr19", 19, 16'h613);
        read_chk("soferr_addr40", 40, 16'h628);

        // ARM_EN dropped mid-fill aborts without touching the published frame.
        send_words(16'h700, 0, 40, 1'b1);
        ARM_EN = 1'b0;
        tick();
        ARM_EN = 1'b1;
        send_words(16'h700, 40, 24, 1'b0);
        chk("abort_ready", {15'd0, ARM_DATA_READY}, 16'd1);
        chk("abort_drop", drop_cnt, 16'd0);
        read_chk("abort_addr0", 0, 16'h600);
        read_chk("abort_addr10", 10, 16'h60A);

        // Reset mid-fill: partial frame is gone, a fresh sof is needed.
        ARM_ACK = 1'b1;
        tick();
        chk("release3_ready", {15'd0, ARM_DATA_READY}, 16'd0);
        ARM_ACK = 1'b0;
        send_words(16'h800, 0, 30, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_soferr", sof_err_cnt, 16'd0);
        tick();
        rst = 1'b0;
        tick();
        send_words(16'h800, 30, 64, 1'b0);
        chk("post_rst_nosof_ready", {15'd0, ARM_DATA_READY}, 16'd0);
        send_words(16'h900, 0, 64, 1'b1);
        chk("post_rst_sof_ready", {15'd0, ARM_DATA_READY}, 16'd1);
        read_chk("post_rst_addr7", 7, 16'h907);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
